// File: rtl/mouse_packet_decoder.sv
// PS/2 mouse packet decoder: assembles 3-byte stream-mode packets, validates framing,
// and integrates the signed deltas into clamped absolute cursor coordinates.
module mouse_packet_decoder #(
  parameter int unsigned X_MAX         = 159,
  parameter int unsigned Y_MAX         = 119,
  parameter int unsigned RESYNC_CYCLES = 2_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic       READ_ENABLE,
  output logic [7:0] MOUSE_X,
  output logic [7:0] MOUSE_Y,
  output logic [7:0] MOUSE_STATUS,
  output logic       PACKET_VALID,
  output logic       PACKET_ERROR
);

  localparam int unsigned CW = (RESYNC_CYCLES > 1) ? $clog2(RESYNC_CYCLES) : 1;
  localparam logic [CW-1:0] TMO = CW'(RESYNC_CYCLES - 1);
  localparam logic [7:0] X_RST = 8'(X_MAX / 2);
  localparam logic [7:0] Y_RST = 8'(Y_MAX / 2);
  localparam logic signed [9:0] X_LIM = 10'(X_MAX);
  localparam logic signed [9:0] Y_LIM = 10'(Y_MAX);

  typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2, UPDATE} state_t;

  state_t state, next_state;

  logic [7:0]    status_buf, dx_buf, dy_buf;
  logic [CW-1:0] cnt, cnt_d;
  logic          take, good, timeout;
  logic          lat_status, lat_dx, lat_dy, do_update, valid_d, err_d;
  logic [8:0]    dx9, dy9;
  logic signed [9:0] x_sum, y_sum;

  function automatic logic [7:0] clamp(input logic signed [9:0] v,
                                       input logic signed [9:0] lim);
    if (v < 0)
      return '0;
    else if (v > lim)
      return lim[7:0];
    else
      return v[7:0];
  endfunction

  always_ff @(posedge CLK) begin
    if (RESET)
      state <= WAIT_B0;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (!ENABLE) begin
      next_state = WAIT_B0;
    end else begin
      case (state)
        WAIT_B0: if (lat_status) next_state = WAIT_B1;
        WAIT_B1: begin
          if (lat_dx)     next_state = WAIT_B2;
          else if (err_d) next_state = WAIT_B0;
        end
        WAIT_B2: begin
          if (lat_dy)     next_state = UPDATE;
          else if (err_d) next_state = WAIT_B0;
        end
        default: next_state = WAIT_B0;
      endcase
    end
  end

  always_comb begin
    take       = ENABLE && BYTE_READY && (state != UPDATE);
    good       = (BYTE_ERROR_CODE == 2'b00);
    timeout    = (cnt == TMO);
    lat_status = 1'b0;
    lat_dx     = 1'b0;
    lat_dy     = 1'b0;
    do_update  = 1'b0;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    if (ENABLE) begin
      case (state)
        WAIT_B0: if (take) begin
          if (good && BYTE_READ[3]) lat_status = 1'b1;
          else                      err_d      = 1'b1;
        end
        WAIT_B1: begin
          if (take) begin
            lat_dx = good;
            err_d  = !good;
          end else if (timeout) begin
            err_d = 1'b1;
          end
        end
        WAIT_B2: begin
          if (take) begin
            lat_dy = good;
            err_d  = !good;
          end else if (timeout) begin
            err_d = 1'b1;
          end
        end
        default: begin
          do_update = 1'b1;
          valid_d   = 1'b1;
        end
      endcase
    end
    // Idle counter only runs while a packet is partially assembled
    if (ENABLE && (state == WAIT_B1 || state == WAIT_B2) && !take && !timeout)
      cnt_d = cnt + 1'b1;
    else
      cnt_d = '0;
  end

  // Overflow forces the delta to its extreme in the direction of the sign bit
  always_comb begin
    dx9   = status_buf[6] ? (status_buf[4] ? 9'h100 : 9'h0FF) : {status_buf[4], dx_buf};
    dy9   = status_buf[7] ? (status_buf[5] ? 9'h100 : 9'h0FF) : {status_buf[5], dy_buf};
    x_sum = $signed({2'b00, MOUSE_X}) + $signed({dx9[8], dx9});
    y_sum = $signed({2'b00, MOUSE_Y}) - $signed({dy9[8], dy9});
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      READ_ENABLE  <= 1'b0;
      MOUSE_X      <= X_RST;
      MOUSE_Y      <= Y_RST;
      MOUSE_STATUS <= '0;
      PACKET_VALID <= 1'b0;
      PACKET_ERROR <= 1'b0;
      status_buf   <= '0;
      dx_buf       <= '0;
      dy_buf       <= '0;
      cnt          <= '0;
    end else begin
      READ_ENABLE  <= ENABLE;
      PACKET_VALID <= valid_d;
      PACKET_ERROR <= err_d;
      cnt          <= cnt_d;
      if (lat_status) status_buf <= BYTE_READ;
      if (lat_dx)     dx_buf     <= BYTE_READ;
      if (lat_dy)     dy_buf     <= BYTE_READ;
      if (do_update) begin
        MOUSE_X      <= clamp(x_sum, X_LIM);
        MOUSE_Y      <= clamp(y_sum, Y_LIM);
        MOUSE_STATUS <= status_buf;
      end
    end
  end

endmodule

// File: tb/tb_mouse_packet_decoder.sv
// Directed-vector bench for mouse_packet_decoder with a shortened resync timeout.
module tb_mouse_packet_decoder;

  localparam int unsigned RESYNC = 16;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       ENABLE = 1'b0;
  logic [7:0] BYTE_READ = '0;
  logic [1:0] BYTE_ERROR_CODE = '0;
  logic       BYTE_READY = 1'b0;
  logic       READ_ENABLE;
  logic [7:0] MOUSE_X, MOUSE_Y, MOUSE_STATUS;
  logic       PACKET_VALID, PACKET_ERROR;

  int n_vec = 0;
  int n_bad = 0;
  int vcnt = 0;
  int ecnt = 0;
  int both_cnt = 0;
  int vbase, ebase;

  mouse_packet_decoder #(.X_MAX(159), .Y_MAX(119), .RESYNC_CYCLES(RESYNC)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE),
    .BYTE_READ(BYTE_READ), .BYTE_ERROR_CODE(BYTE_ERROR_CODE), .BYTE_READY(BYTE_READY),
    .READ_ENABLE(READ_ENABLE), .MOUSE_X(MOUSE_X), .MOUSE_Y(MOUSE_Y),
    .MOUSE_STATUS(MOUSE_STATUS), .PACKET_VALID(PACKET_VALID), .PACKET_ERROR(PACKET_ERROR)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (PACKET_VALID) vcnt++;
    if (PACKET_ERROR) ecnt++;
    if (PACKET_VALID && PACKET_ERROR) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mark();
    vbase = vcnt;
    ebase = ecnt;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    ENABLE = 1'b0;
    BYTE_READY = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    ENABLE = 1'b1;
    @(negedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [1:0] ec);
    @(negedge CLK);
    BYTE_READ = b;
    BYTE_ERROR_CODE = ec;
    BYTE_READY = 1'b1;
    @(negedge CLK);
    BYTE_READY = 1'b0;
    BYTE_ERROR_CODE = 2'b00;
  endtask

  // Sends a clean packet and checks the two-cycle latency of PACKET_VALID
  task automatic pkt(input string tag, input logic [7:0] b0, b1, b2);
    mark();
    send_byte(b0, 2'b00);
    send_byte(b1, 2'b00);
    send_byte(b2, 2'b00);
    check({tag, "_early"}, PACKET_VALID, 0);
    @(negedge CLK);
    check({tag, "_valid"}, PACKET_VALID, 1);
    repeat (2) @(negedge CLK);
    check({tag, "_vcount"}, vcnt - vbase, 1);
    check({tag, "_ecount"}, ecnt - ebase, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_x", MOUSE_X, 8'd79);
    check("rst_y", MOUSE_Y, 8'd59);
    check("rst_status", MOUSE_STATUS, 8'h00);
    check("rst_valid", PACKET_VALID, 0);
    check("rst_error", PACKET_ERROR, 0);
    check("rst_rden", READ_ENABLE, 0);
    RESET = 1'b0;
    ENABLE = 1'b1;
    check("rden_lag", READ_ENABLE, 0);
    @(negedge CLK);
    check("rden_on", READ_ENABLE, 1);

    // 1: basic packet
    pkt("t1", 8'h08, 8'h05, 8'h03);
    check("t1_x", MOUSE_X, 8'd84);
    check("t1_y", MOUSE_Y, 8'd56);
    check("t1_status", MOUSE_STATUS, 8'h08);

    // 2: negative dx and clamp at 0
    do_reset();
    pkt("t2a", 8'h18, 8'hF6, 8'h00);
    check("t2a_x", MOUSE_X, 8'd69);
    check("t2a_y", MOUSE_Y, 8'd59);
    pkt("t2b", 8'h18, 8'h80, 8'h00);
    check("t2b_x", MOUSE_X, 8'd0);
    check("t2b_status", MOUSE_STATUS, 8'h18);

    // 3: overflow and Y clamps
    do_reset();
    pkt("t3a", 8'h48, 8'h00, 8'h00);
    check("t3a_x", MOUSE_X, 8'd159);
    pkt("t3b", 8'h28, 8'h00, 8'hFF);
    check("t3b_y", MOUSE_Y, 8'd60);
    pkt("t3c", 8'h28, 8'h00, 8'h80);
    check("t3c_y", MOUSE_Y, 8'd119);
    pkt("t3d", 8'h88, 8'h00, 8'h00);
    check("t3d_y", MOUSE_Y, 8'd0);
    check("t3d_x", MOUSE_X, 8'd159);
    check("t3d_status", MOUSE_STATUS, 8'h88);

    // 4: misaligned first byte
    do_reset();
    mark();
    send_byte(8'h00, 2'b00);
    @(negedge CLK);
    check("t4_err", ecnt - ebase, 1);
    pkt("t4", 8'h08, 8'h01, 8'h01);
    check("t4_x", MOUSE_X, 8'd80);
    check("t4_y", MOUSE_Y, 8'd58);

    // 5: parity error on byte 1, stop-bit error on byte 0
    mark();
    send_byte(8'h08, 2'b00);
    send_byte(8'h05, 2'b01);
    @(negedge CLK);
    check("t5_err", ecnt - ebase, 1);
    check("t5_x", MOUSE_X, 8'd80);
    check("t5_y", MOUSE_Y, 8'd58);
    mark();
    send_byte(8'h08, 2'b10);
    @(negedge CLK);
    check("t5_stop_err", ecnt - ebase, 1);
    pkt("t5", 8'h08, 8'h02, 8'h00);
    check("t5_realign_x", MOUSE_X, 8'd82);
    check("t5_realign_y", MOUSE_Y, 8'd58);

    // 6: resync timeout
    do_reset();
    mark();
    send_byte(8'h08, 2'b00);
    send_byte(8'h08, 2'b00);
    repeat (RESYNC - 6) @(negedge CLK);
    check("t6_no_early_err", ecnt - ebase, 0);
    for (int i = 0; i < 40 && ecnt == ebase; i++) @(negedge CLK);
    check("t6_timeout_err", ecnt - ebase, 1);
    check("t6_no_valid", vcnt - vbase, 0);
    pkt("t6", 8'h08, 8'h02, 8'h02);
    check("t6_x", MOUSE_X, 8'd81);
    check("t6_y", MOUSE_Y, 8'd57);

    // 6b: ENABLE drop mid-packet
    do_reset();
    mark();
    send_byte(8'h08, 2'b00);
    send_byte(8'h05, 2'b00);
    ENABLE = 1'b0;
    check("t6b_rden_lag", READ_ENABLE, 1);
    @(negedge CLK);
    check("t6b_rden_off", READ_ENABLE, 0);
    send_byte(8'h00, 2'b00);
    repeat (RESYNC + 8) @(negedge CLK);
    check("t6b_no_err", ecnt - ebase, 0);
    ENABLE = 1'b1;
    @(negedge CLK);
    send_byte(8'h03, 2'b00);
    repeat (2) @(negedge CLK);
    check("t6b_dropped_err", ecnt - ebase, 1);
    check("t6b_no_valid", vcnt - vbase, 0);
    check("t6b_hold_x", MOUSE_X, 8'd79);
    pkt("t6b", 8'h08, 8'h01, 8'h01);
    check("t6b_x", MOUSE_X, 8'd80);
    check("t6b_y", MOUSE_Y, 8'd58);

    // Mid-packet reset
    send_byte(8'h08, 2'b00);
    do_reset();
    check("rst2_x", MOUSE_X, 8'd79);
    check("rst2_status", MOUSE_STATUS, 8'h00);
    pkt("rst2", 8'h08, 8'h05, 8'h03);
    check("rst2_pkt_x", MOUSE_X, 8'd84);

    check("valid_err_exclusive", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
